// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_pkg
//  Purpose  : Shared types for the generic pipeline-stage buffer.
//             occ_e encodes how many payloads the stage currently holds.
//  Ports    : (package, no ports)
//  Revision : 1.0  initial release
// ============================================================================
package pipe_pkg;

  // Occupancy of the stage: the encoding equals the number of held entries.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // True when the skid variant can still take another payload.
  function automatic logic occ_has_room(input occ_e occ);
    return (occ != OCC_TWO);
  endfunction

  // True when the stage presents a payload downstream.
  function automatic logic occ_has_data(input occ_e occ);
    return (occ != OCC_EMPTY);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_sat_counter
//  Purpose  : Saturating event counter. Counts cycles with inc=1, sticks at
//             all-ones, and is cleared synchronously by clr (clr beats inc).
//  Ports    : clk   in   clock, rising edge
//             rst   in   asynchronous reset, active-low
//             inc   in   count this cycle
//             clr   in   synchronous clear
//             count out  CNT_WIDTH current count
//  Revision : 1.0  initial release
// ============================================================================
module pipe_sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != CNT_MAX)) begin
      // Stop at all-ones so a long stall never wraps back to a small value.
      count_d = count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_buf.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_stage_buf
//  Purpose  : Generic pipeline-stage register with valid/ready flow control.
//             SKID=1 : two-entry skid buffer, in_ready comes from a flop.
//             SKID=0 : single register, in_ready = !out_valid | out_ready.
//             flush drops every held payload and presents an all-zero
//             bubble; stall_cnt counts out_valid & !out_ready cycles.
//  Ports    : clk        in   clock, rising edge
//             rst        in   asynchronous reset, active-low
//             flush      in   synchronous flush (highest priority)
//             in_valid   in   upstream payload valid
//             in_ready   out  stage accepts payload this cycle
//             in_data    in   DATA_WIDTH upstream payload
//             out_valid  out  payload presented downstream
//             out_ready  in   downstream accepts payload this cycle
//             out_data   out  DATA_WIDTH payload (main register)
//             clr_stats  in   synchronous clear of stall_cnt
//             stall_cnt  out  CNT_WIDTH saturating stall-cycle count
//  Revision : 1.0  initial release
// ============================================================================
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int SKID       = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  clr_stats,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  logic in_fire;
  logic out_fire;

  assign in_fire  = in_valid  & in_ready;
  assign out_fire = out_valid & out_ready;

  generate
    if (SKID != 0) begin : g_skid
      // ----------------------------------------------------------------
      // Two-entry variant. main_q is always the head of the queue; skid_q
      // only holds a payload while in OCC_TWO. Because in_ready depends
      // only on the state flop, the upstream ready path is fully
      // registered and the stage can absorb one extra beat after the
      // downstream stalls.
      // ----------------------------------------------------------------
      occ_e                  state_q;
      occ_e                  state_d;
      logic [DATA_WIDTH-1:0] main_q;
      logic [DATA_WIDTH-1:0] main_d;
      logic [DATA_WIDTH-1:0] skid_q;
      logic [DATA_WIDTH-1:0] skid_d;

      always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
          // Bubble: all-zero payload so downstream control decodes as a no-op;
          // a payload accepted in the same cycle is dropped on purpose.
          state_d = OCC_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end else begin
          case (state_q)
            OCC_EMPTY: begin
              if (in_fire) begin
                state_d = OCC_ONE;
                main_d  = in_data;
              end
            end
            OCC_ONE: begin
              if (in_fire && out_fire) begin
                main_d = in_data;
              end else if (in_fire) begin
                state_d = OCC_TWO;
                skid_d  = in_data;
              end else if (out_fire) begin
                state_d = OCC_EMPTY;
              end
            end
            OCC_TWO: begin
              // in_ready is low here, so only the drain path can move.
              if (out_fire) begin
                state_d = OCC_ONE;
                main_d  = skid_q;
              end
            end
            default: begin
              state_d = OCC_EMPTY;
            end
          endcase
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_q <= OCC_EMPTY;
          main_q  <= '0;
          skid_q  <= '0;
        end else begin
          state_q <= state_d;
          main_q  <= main_d;
          skid_q  <= skid_d;
        end
      end

      assign in_ready  = occ_has_room(state_q);
      assign out_valid = occ_has_data(state_q);
      assign out_data  = main_q;

    end else begin : g_single
      // ----------------------------------------------------------------
      // Single-register variant. Ready is combinational so the stage can
      // accept a new beat in the same cycle the held one leaves.
      // ----------------------------------------------------------------
      logic                  valid_q;
      logic                  valid_d;
      logic [DATA_WIDTH-1:0] main_q;
      logic [DATA_WIDTH-1:0] main_d;

      always_comb begin
        valid_d = valid_q;
        main_d  = main_q;
        if (flush) begin
          valid_d = 1'b0;
          main_d  = '0;
        end else if (in_fire) begin
          valid_d = 1'b1;
          main_d  = in_data;
        end else if (out_fire) begin
          valid_d = 1'b0;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          valid_q <= 1'b0;
          main_q  <= '0;
        end else begin
          valid_q <= valid_d;
          main_q  <= main_d;
        end
      end

      assign in_ready  = ~valid_q | out_ready;
      assign out_valid = valid_q;
      assign out_data  = main_q;
    end
  endgenerate

  // Stall accounting is shared by both variants and ignores flush.
  pipe_sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (out_valid & ~out_ready),
    .clr   (clr_stats),
    .count (stall_cnt)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_buf.sv
`timescale 1ns/1ps
module tb_pipe_stage_buf;

  logic       clk;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       clr_stats;

  logic        ir_a, ov_a, ir_b, ov_b, ir_c, ov_c;
  logic [7:0]  od_a, od_b, od_c;
  logic [15:0] sc_a;
  logic [7:0]  sc_b;
  logic [3:0]  sc_c;

  // A: skid, 16-bit counter. B: single register. C: skid, 4-bit counter.
  pipe_stage_buf #(.DATA_WIDTH(8), .SKID(1), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_a),
    .in_data(in_data), .out_valid(ov_a), .out_ready(out_ready), .out_data(od_a),
    .clr_stats(clr_stats), .stall_cnt(sc_a));
  pipe_stage_buf #(.DATA_WIDTH(8), .SKID(0), .CNT_WIDTH(8)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_b),
    .in_data(in_data), .out_valid(ov_b), .out_ready(out_ready), .out_data(od_b),
    .clr_stats(clr_stats), .stall_cnt(sc_b));
  pipe_stage_buf #(.DATA_WIDTH(8), .SKID(1), .CNT_WIDTH(4)) dut_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir_c),
    .in_data(in_data), .out_valid(ov_c), .out_ready(out_ready), .out_data(od_c),
    .clr_stats(clr_stats), .stall_cnt(sc_c));

  logic        ir [3];
  logic        ov [3];
  logic [7:0]  od [3];
  logic [31:0] sc [3];
  assign ir[0] = ir_a; assign ir[1] = ir_b; assign ir[2] = ir_c;
  assign ov[0] = ov_a; assign ov[1] = ov_b; assign ov[2] = ov_c;
  assign od[0] = od_a; assign od[1] = od_b; assign od[2] = od_c;
  assign sc[0] = {16'b0, sc_a}; assign sc[1] = {24'b0, sc_b}; assign sc[2] = {28'b0, sc_c};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got %0h, expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  // ---------------- reference model: a bounded FIFO per instance ----------
  int         occ  [3];
  logic [7:0] mem  [3][2];
  logic [7:0] last [3];
  int         cnt  [3];

  function automatic bit is_skid(input int i);
    return (i != 1);
  endfunction

  function automatic int cmax(input int i);
    case (i)
      0:       return 65535;
      1:       return 255;
      default: return 15;
    endcase
  endfunction

  function automatic bit exp_ready(input int i);
    if (is_skid(i)) return (occ[i] < 2);
    return (occ[i] == 0) || out_ready;
  endfunction

  function automatic logic [7:0] exp_data(input int i);
    return (occ[i] > 0) ? mem[i][0] : last[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      occ[i] = 0; last[i] = 8'h00; cnt[i] = 0;
      mem[i][0] = 8'h00; mem[i][1] = 8'h00;
    end
  endtask

  task automatic model_check();
    for (int i = 0; i < 3; i++) begin
      chk("out_valid", i, {31'b0, ov[i]}, {31'b0, occ[i] > 0});
      chk("in_ready",  i, {31'b0, ir[i]}, {31'b0, exp_ready(i)});
      chk("out_data",  i, {24'b0, od[i]}, {24'b0, exp_data(i)});
      chk("stall_cnt", i, sc[i], cnt[i]);
    end
  endtask

  // Advance the model by one clock edge using the inputs in force now.
  task automatic model_edge();
    bit rdy, ofire, ifire;
    for (int i = 0; i < 3; i++) begin
      rdy   = exp_ready(i);
      ofire = (occ[i] > 0) && out_ready;
      ifire = in_valid && rdy;
      if (clr_stats) cnt[i] = 0;
      else if (occ[i] > 0 && !out_ready && cnt[i] < cmax(i)) cnt[i]++;
      if (flush) begin
        occ[i] = 0; last[i] = 8'h00;
      end else begin
        if (ofire) begin
          last[i] = mem[i][0]; mem[i][0] = mem[i][1]; occ[i]--;
        end
        if (ifire) begin
          mem[i][occ[i]] = in_data; occ[i]++;
        end
      end
    end
  endtask

  // ---------------- directed vector table (instance A) --------------------
  typedef struct {
    logic       fl;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       clr;
    logic       eov;
    logic [7:0] eod;
    logic       eir;
    int         esc;
  } vec_t;

  vec_t vecs [32];
  int   nvec = 0;
  bit   use_vec = 0;
  vec_t cur;

  task automatic add(input logic fl, input logic iv, input logic [7:0] id, input logic ordy,
                     input logic clr, input logic eov, input logic [7:0] eod, input logic eir,
                     input int esc);
    vecs[nvec] = '{fl, iv, id, ordy, clr, eov, eod, eir, esc};
    nvec++;
  endtask

  // One clock: check pre-edge outputs, cross the edge, update model.
  task automatic cycle();
    #1;
    model_check();
    if (use_vec) begin
      chk("vec_out_valid", 0, {31'b0, ov_a}, {31'b0, cur.eov});
      chk("vec_out_data",  0, {24'b0, od_a}, {24'b0, cur.eod});
      chk("vec_in_ready",  0, {31'b0, ir_a}, {31'b0, cur.eir});
      chk("vec_stall_cnt", 0, {16'b0, sc_a}, cur.esc);
    end
    @(posedge clk);
    if (!rst) model_reset();
    else      model_edge();
    #1;
  endtask

  task automatic drive(input logic fl, input logic iv, input logic [7:0] id,
                       input logic ordy, input logic clr);
    flush = fl; in_valid = iv; in_data = id; out_ready = ordy; clr_stats = clr;
  endtask

  initial begin
    rst = 1'b0;
    drive(0, 0, 8'h00, 0, 0);
    model_reset();

    // Streaming 0x1..0x8 with out_ready high: one cycle lag, one per cycle.
    for (int k = 0; k < 8; k++)
      add(0, 1, 8'(k + 1), 1, 0, (k != 0), 8'(k), 1, 0);
    add(0, 0, 8'h00, 1, 0, 1, 8'h08, 1, 0);
    add(0, 0, 8'h00, 1, 0, 0, 8'h08, 1, 0);
    // Backpressure: A, B taken, C held upstream, then released.
    add(0, 1, 8'h0A, 0, 0, 0, 8'h08, 1, 0);
    add(0, 1, 8'h0B, 0, 0, 1, 8'h0A, 1, 0);
    add(0, 1, 8'h0C, 0, 0, 1, 8'h0A, 0, 1);
    add(0, 1, 8'h0C, 0, 0, 1, 8'h0A, 0, 2);
    add(0, 1, 8'h0C, 1, 0, 1, 8'h0A, 0, 3);
    add(0, 1, 8'h0C, 1, 0, 1, 8'h0B, 1, 3);
    add(0, 0, 8'h00, 1, 0, 1, 8'h0C, 1, 3);
    add(0, 0, 8'h00, 1, 0, 0, 8'h0C, 1, 3);
    add(0, 0, 8'h00, 1, 1, 0, 8'h0C, 1, 3);
    add(0, 0, 8'h00, 1, 0, 0, 8'h0C, 1, 0);
    // Flush while holding A, B with C offered the same cycle.
    add(0, 1, 8'h0A, 0, 0, 0, 8'h0C, 1, 0);
    add(0, 1, 8'h0B, 0, 0, 1, 8'h0A, 1, 0);
    add(1, 1, 8'h0C, 0, 0, 1, 8'h0A, 0, 1);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 2);
    add(0, 0, 8'h00, 1, 0, 0, 8'h00, 1, 2);

    #2;
    model_check();  // reset values while rst is held low
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < nvec; k++) begin
      cur = vecs[k];
      drive(cur.fl, cur.iv, cur.id, cur.ordy, cur.clr);
      use_vec = 1;
      cycle();
    end
    use_vec = 0;

    // Saturation on the 4-bit counter: load one entry, stall 20 cycles.
    drive(0, 1, 8'h05, 0, 0);
    cycle();
    for (int k = 0; k < 20; k++) begin
      drive(0, 0, 8'h00, 0, 0);
      cycle();
    end
    chk("sat_stall_cnt", 2, {28'b0, sc_c}, 32'd15);
    drive(0, 0, 8'h00, 0, 1);
    cycle();
    chk("clr_during_stall", 2, {28'b0, sc_c}, 32'd0);
    drive(0, 0, 8'h00, 0, 0);
    cycle();
    chk("count_after_clr", 2, {28'b0, sc_c}, 32'd1);

    // Reset mid-stream with two entries held in the skid instance.
    drive(0, 1, 8'h06, 0, 0);
    cycle();
    drive(0, 1, 8'h07, 0, 0);
    rst = 1'b0;
    #1;
    model_reset();
    chk("rst_out_valid", 0, {31'b0, ov_a}, 32'd0);
    chk("rst_out_data",  0, {24'b0, od_a}, 32'd0);
    chk("rst_in_ready",  0, {31'b0, ir_a}, 32'd1);
    chk("rst_stall_cnt", 0, {16'b0, sc_a}, 32'd0);
    cycle();
    rst = 1'b1;

    // Single-register instance: out_ready toggling with continuous in_valid.
    for (int k = 0; k < 16; k++) begin
      drive(0, 1, 8'(8'h40 + k), (k % 2 == 0), 0);
      cycle();
    end

    // Random traffic against the model.
    for (int k = 0; k < 400; k++) begin
      drive(($urandom_range(0, 99) < 3), ($urandom_range(0, 9) < 7), 8'($urandom),
            ($urandom_range(0, 9) < 6), ($urandom_range(0, 99) < 3));
      cycle();
    end
    drive(0, 0, 8'h00, 1, 0);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
